// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: the timing-engine state encoding, frame
// geometry constants and the frame-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } rx_state_e;

    localparam int PRESCALE_MIN   = 4;
    localparam int DATA_BITS_BASE = 5;
    localparam int FRAME_LEN_MAX  = 12;
    localparam int FRAME_LEN_W    = $clog2(FRAME_LEN_MAX + 1);

    // start + data + optional parity + first stop + optional second stop
    function automatic logic [FRAME_LEN_W-1:0] calc_frame_len(
        input logic [1:0] data_bits_sel,
        input logic       parity_en,
        input logic       stop2
    );
        return FRAME_LEN_W'(1 + DATA_BITS_BASE + int'(data_bits_sel)
                            + int'(parity_en) + 1 + int'(stop2));
    endfunction

endpackage

// File: rtl/uart_rx_frame_counter.sv
// Oversampling timing engine for the UART receiver: counts clocks per bit and
// bits per frame, and decodes the sample strobes and bit/frame completion.
module uart_rx_frame_counter
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            data_bits_sel,
    input  logic                  parity_en,
    input  logic                  stop2,
    output logic [PRESCALE_W-1:0] edge_counter,
    output logic [BIT_W-1:0]      bit_counter,
    output logic [2:0]            sample_strobe,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_error
);

    rx_state_e             state_q,     state_d;
    logic [PRESCALE_W-1:0] edge_q,      edge_d;
    logic [BIT_W-1:0]      bit_q,       bit_d;
    logic [PRESCALE_W-1:0] p_q,         p_d;
    logic [BIT_W-1:0]      frame_len_q, frame_len_d;
    logic                  cfg_error_q, cfg_error_d;

    logic                  prescale_legal;
    logic                  running;
    logic [PRESCALE_W-1:0] mid;
    logic                  last_edge;
    logic                  last_bit;

    assign prescale_legal = (prescale >= PRESCALE_W'(PRESCALE_MIN));
    assign running        = (state_q == RUN);
    assign mid            = p_q >> 1;
    assign last_edge      = (edge_q == p_q);
    assign last_bit       = (bit_q == frame_len_q);

    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        bit_d       = bit_q;
        p_d         = p_q;
        frame_len_d = frame_len_q;
        cfg_error_d = cfg_error_q;

        unique case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (enable) begin
                    if (prescale_legal) begin
                        state_d     = RUN;
                        edge_d      = PRESCALE_W'(1);
                        bit_d       = BIT_W'(1);
                        p_d         = prescale;
                        frame_len_d = BIT_W'(calc_frame_len(data_bits_sel, parity_en, stop2));
                        cfg_error_d = 1'b0;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end

            RUN: begin
                // Dropping enable wins over any in-frame update, frame_done included.
                if (!enable) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (last_edge && last_bit) begin
                    state_d = HOLD;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (last_edge) begin
                    edge_d = PRESCALE_W'(1);
                    bit_d  = bit_q + BIT_W'(1);
                end else begin
                    edge_d = edge_q + PRESCALE_W'(1);
                end
            end

            HOLD: begin
                // Parked until enable falls so a stuck-high enable cannot start a second frame.
                edge_d = '0;
                bit_d  = '0;
                if (!enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            edge_q      <= '0;
            bit_q       <= '0;
            p_q         <= '0;
            frame_len_q <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            p_q         <= p_d;
            frame_len_q <= frame_len_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign edge_counter     = edge_q;
    assign bit_counter      = bit_q;
    assign cfg_error        = cfg_error_q;

    assign sample_strobe[0] = running && (edge_q == mid - PRESCALE_W'(1));
    assign sample_strobe[1] = running && (edge_q == mid);
    assign sample_strobe[2] = running && (edge_q == mid + PRESCALE_W'(1));
    assign bit_done         = running && last_edge;
    assign frame_done       = bit_done && last_bit;

endmodule

// File: doc/uart_rx_frame_counter.md
# uart_rx_frame_counter

Parametrised oversampling timing engine for the UART receiver. It counts clock edges within each bit period and bits within each frame, and it decodes the majority-vote sample strobes, per-bit completion and whole-frame completion. Frame length is configurable: data width, optional parity, 1 or 2 stop bits. It sits between the RX FSM (which drives `enable`) and the data sampler, deserializer and parity/stop checkers.

## Interface
- `PRESCALE_W`, default 6: width of the prescale input and of `edge_counter`.
- `BIT_W`, default 4: width of `bit_counter`; must hold the maximum frame length of 12.
- `clock` input, 1 bit: clock.
- `reset` input, 1 bit: reset, asynchronous, active-low.
- `enable` input, 1 bit: from the RX FSM; high while a frame is being received.
- `prescale` input, `PRESCALE_W` bits: clocks per bit; legal values 4..2^PRESCALE_W−1.
- `data_bits_sel` input, 2 bits: data width; 00 = 5, 01 = 6, 10 = 7, 11 = 8.
- `parity_en` input, 1 bit: adds one parity bit to the frame.
- `stop2` input, 1 bit: adds a second stop bit to the frame.
- `edge_counter` output, `PRESCALE_W` bits: position within the bit period, 1..prescale; 0 when not running.
- `bit_counter` output, `BIT_W` bits: position within the frame, 1..frame_len; 0 when not running.
- `sample_strobe` output, 3 bits: majority-vote sample points.
- `bit_done` output, 1 bit: last edge of the current bit.
- `frame_done` output, 1 bit: last edge of the last bit of the frame.
- `cfg_error` output, 1 bit: illegal prescale seen at frame start.

## Operation
- States: IDLE, RUN, HOLD.
- Configuration is latched on the IDLE→RUN transition: `p` = prescale, `frame_len` = 1 + (5 + data_bits_sel) + parity_en + 1 + stop2, giving a range of 7..12.
  - Config inputs that change during RUN or HOLD are ignored until the next frame start.
- IDLE: counters are 0.
  - `enable`=1 with prescale ≥ 4: go to RUN, edge_counter←1, bit_counter←1.
  - `enable`=1 with prescale < 4: stay in IDLE, cfg_error←1. cfg_error is sticky until the next legal start or reset.
- RUN, no terminal condition: edge_counter increments each clock.
- RUN, edge_counter == p and bit_counter < frame_len: edge_counter←1, bit_counter+1.
- RUN, edge_counter == p and bit_counter == frame_len: go to HOLD, both counters←0.
- RUN or HOLD, `enable`=0: go to IDLE, both counters←0. This takes priority over all RUN updates, including a simultaneous frame_done.
- HOLD: counters stay 0 while `enable` remains high. The block re-arms only after `enable` drops to 0, which prevents a runaway second frame.
- Decodes, using mid = p>>1 (logical shift):
  - `sample_strobe[0]` = RUN && edge_counter == mid−1.
  - `sample_strobe[1]` = RUN && edge_counter == mid.
  - `sample_strobe[2]` = RUN && edge_counter == mid+1.
  - `bit_done` = RUN && edge_counter == p.
  - `frame_done` = bit_done && bit_counter == frame_len.
- Arithmetic: edge_counter never exceeds p and bit_counter never exceeds frame_len. No wrap through 0 occurs inside RUN.

## Timing
- Reset values: state IDLE; edge_counter, bit_counter and cfg_error are 0. With all registers 0, every decoded output is also 0.
- Counters and state are registered. The decoded outputs are combinational from the registered state and counters, valid in the same cycle as the counter values, with no extra latency.
- Start latency: `enable` sampled high at clock edge k gives edge_counter=1, bit_counter=1 after edge k.
- A frame occupies exactly p·frame_len cycles of RUN. frame_done is high for exactly one cycle, the last of those.
- Reset asserted mid-frame clears everything asynchronously. Operation resumes from IDLE on the first clock after reset is released.

## Structure
- Shared `uart_pkg` holds:
  - the state enum (IDLE/RUN/HOLD);
  - `PRESCALE_MIN` = 4;
  - `DATA_BITS_BASE` = 5;
  - `FRAME_LEN_MAX` = 12.
- Single module; no sub-module. The frame-length adder and the strobe decode are small enough to stay inline.

## Test plan
- **Baseline frame:** p=8, 8 data bits, no parity, 1 stop, `enable` held high → frame_len=10; frame_done is a single pulse exactly 80 cycles after the start edge with edge=8, bit=10; then HOLD, counters 0.
- **Long frame and odd prescale:** p=16, 5 data bits, parity on, 2 stops → frame_len=9, frame_done at cycle 144. Then p=5: mid=2, strobes at edges 1/2/3 each bit; bit_done at edge 5.
- **Illegal prescale:** p=3 with enable high → cfg_error=1, stays IDLE, counters 0. A following legal p=8 start clears cfg_error.
- **Abort and re-arm:** `enable` dropped at bit 4, edge 6 → next cycle IDLE, counters 0, no frame_done. Separately, holding `enable` high after frame_done → counters stay 0 until an `enable` 0→1 cycle restarts at 1/1.
- **Config change mid-frame:** change prescale from 8 to 16 and toggle parity_en during RUN → current frame still ends at cycle 80. The next frame uses the new values.
- **Async reset mid-frame:** assert reset at bit 6 → all outputs 0 immediately. Release, then `enable` high → a normal start at 1/1 on the next edge.
